// File: rtl/hpi_pkg.sv
// Shared types and default timing for the HPI timed master.
//   hpi_state_e    : master sequencing states
//   HPI_*_DEF      : default setup/strobe/hold/chip-reset lengths in clk cycles
//   hpi_max4       : largest of four lengths, used to size the phase counter
package hpi_pkg;

   typedef enum logic [2:0] {
      RST_PULSE,
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } hpi_state_e;

   localparam int HPI_SETUP_DEF  = 1;
   localparam int HPI_STROBE_DEF = 2;
   localparam int HPI_HOLD_DEF   = 1;
   localparam int HPI_RST_DEF    = 16;

   function automatic int hpi_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter shared by every phase of the HPI master.
//   Clk, Reset : clock, synchronous active-high reset (loads RST_VAL)
//   load       : load load_val this cycle instead of counting
//   load_val   : phase length in cycles
//   value      : current count
//   expire     : high in the last cycle of the phase (value == 1)
module hpi_phase_timer #(
   parameter int CNT_W   = 5,
   parameter int RST_VAL = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] value,
   output logic             expire
);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         value <= CNT_W'(RST_VAL);
      end else if (load) begin
         value <= load_val;
      end else if (value != '0) begin
         value <= value - CNT_W'(1);
      end
   end

   assign expire = (value == CNT_W'(1));

endmodule

// File: rtl/hpi_timed_master.sv
// Timed bus master for the CY7C67200 Host Port Interface. Turns a
// valid/ready request into a CS/ADDR/RD/WR strobe sequence with
// programmable setup, strobe and hold lengths, and generates power-on and
// software-requested chip reset pulses.
//   Clk, Reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_write/addr/wdata  : request fields (1 = write)
//   sw_rst_req            : single-cycle chip reset request
//   done                  : one-cycle pulse at transaction end
//   rsp_rdata             : read data, held until the next read completes
//   busy                  : state is not IDLE
//   OTG_*                 : HPI pins, all driven from flops
//
// state     | meaning
// RST_PULSE | OTG_RST_N low for RST_CYC cycles, no requests taken
// IDLE      | ready for a request or a soft reset
// SETUP     | CS_N low, address (and write data) set up
// STROBE    | RD_N or WR_N low, read data sampled on the final edge
// HOLD      | strobe released, CS_N/ADDR/data held
module hpi_timed_master
   import hpi_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 2,
   parameter int SETUP_CYC  = HPI_SETUP_DEF,
   parameter int STROBE_CYC = HPI_STROBE_DEF,
   parameter int HOLD_CYC   = HPI_HOLD_DEF,
   parameter int RST_CYC    = HPI_RST_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              sw_rst_req,
   output logic              done,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   inout  wire  [DATA_W-1:0] OTG_DATA,
   output logic [ADDR_W-1:0] OTG_ADDR,
   output logic              OTG_RD_N,
   output logic              OTG_WR_N,
   output logic              OTG_CS_N,
   output logic              OTG_RST_N
);

   localparam int MAX_CYC = hpi_max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   hpi_state_e        state, state_nxt;
   logic              accept;
   logic              rst_pend;
   logic              wr_q, wr_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [DATA_W-1:0] dout_q;
   logic              oe_q;
   logic              active_nxt;
   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_load_val;
   logic [CNT_W-1:0]  tmr_value_unused;
   logic              tmr_expire;

   hpi_phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (RST_CYC)
   ) u_timer (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value_unused),
      .expire   (tmr_expire)
   );

   // A pending or same-cycle soft reset masks ready so it wins over a request.
   assign req_ready = (state == IDLE) && !sw_rst_req && !rst_pend;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);

   // Pins are registered from next-cycle values so they line up with the state.
   assign wr_nxt     = accept ? req_write : wr_q;
   assign addr_nxt   = accept ? req_addr  : addr_q;
   assign wdata_nxt  = accept ? req_wdata : wdata_q;
   assign active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);

   always_comb begin
      state_nxt = state;
      case (state)
         RST_PULSE: if (tmr_expire) state_nxt = IDLE;
         IDLE: begin
            if (sw_rst_req || rst_pend) state_nxt = RST_PULSE;
            else if (accept)            state_nxt = SETUP;
         end
         SETUP:     if (tmr_expire) state_nxt = STROBE;
         STROBE:    if (tmr_expire) state_nxt = HOLD;
         HOLD:      if (tmr_expire) state_nxt = IDLE;
         default:   state_nxt = RST_PULSE;
      endcase
   end

   always_comb begin
      tmr_load     = (state_nxt != state);
      tmr_load_val = '0;
      case (state_nxt)
         RST_PULSE: tmr_load_val = CNT_W'(RST_CYC);
         SETUP:     tmr_load_val = CNT_W'(SETUP_CYC);
         STROBE:    tmr_load_val = CNT_W'(STROBE_CYC);
         HOLD:      tmr_load_val = CNT_W'(HOLD_CYC);
         default:   tmr_load_val = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= RST_PULSE;
         rst_pend  <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         dout_q    <= '0;
         oe_q      <= 1'b0;
         done      <= 1'b0;
         rsp_rdata <= '0;
         OTG_ADDR  <= '0;
         OTG_RD_N  <= 1'b1;
         OTG_WR_N  <= 1'b1;
         OTG_CS_N  <= 1'b1;
         OTG_RST_N <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         // IDLE always acts on a pending request, so it can be dropped there.
         if (state == IDLE)   rst_pend <= 1'b0;
         else if (sw_rst_req) rst_pend <= 1'b1;

         OTG_RST_N <= (state_nxt != RST_PULSE);
         OTG_CS_N  <= !active_nxt;
         OTG_RD_N  <= !((state_nxt == STROBE) && !wr_nxt);
         OTG_WR_N  <= !((state_nxt == STROBE) && wr_nxt);
         OTG_ADDR  <= addr_nxt;
         dout_q    <= wdata_nxt;
         oe_q      <= active_nxt && wr_nxt;
         done      <= (state == HOLD) && tmr_expire;
         if ((state == STROBE) && tmr_expire && !wr_q) rsp_rdata <= OTG_DATA;
      end
   end

   assign OTG_DATA = oe_q ? dout_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_hpi_timed_master.sv
module tb_hpi_timed_master;

   // Hand-derived timing for the default build (S=1, P=2, H=1, RST=16).
   localparam int T_DONE = 5;
   localparam int T_CS   = 4;
   localparam int T_STB  = 2;
   localparam int T_OFF  = 1;
   localparam int T_RST  = 16;
   // Wide build with STROBE_CYC=4: done at 1+4+1+1.
   localparam int T2_DONE = 7;
   localparam int T2_STB  = 4;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic        Reset, Reset2;
   logic        req_valid, req_write, sw_rst_req, req_ready, done, busy;
   logic [1:0]  req_addr, otg_addr;
   logic [15:0] req_wdata, rsp_rdata;
   logic        otg_rd_n, otg_wr_n, otg_cs_n, otg_rst_n;
   tri1  [15:0] otg_data;

   logic        req2_valid, req2_write, sw_rst2_req, req2_ready, done2, busy2;
   logic [1:0]  req2_addr, otg2_addr;
   logic [31:0] req2_wdata, rsp2_rdata;
   logic        otg2_rd_n, otg2_wr_n, otg2_cs_n, otg2_rst_n;
   tri1  [31:0] otg2_data;

   logic [15:0] dev_rom [4];
   assign otg_data  = otg_rd_n  ? 16'hzzzz : dev_rom[otg_addr];
   assign otg2_data = otg2_rd_n ? 32'hzzzzzzzz : 32'hCAFEF00D;

   hpi_timed_master dut (
      .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .sw_rst_req(sw_rst_req), .done(done), .rsp_rdata(rsp_rdata), .busy(busy),
      .OTG_DATA(otg_data), .OTG_ADDR(otg_addr), .OTG_RD_N(otg_rd_n),
      .OTG_WR_N(otg_wr_n), .OTG_CS_N(otg_cs_n), .OTG_RST_N(otg_rst_n)
   );

   hpi_timed_master #(.DATA_W(32), .STROBE_CYC(4)) dut2 (
      .Clk(Clk), .Reset(Reset2), .req_valid(req2_valid), .req_ready(req2_ready),
      .req_write(req2_write), .req_addr(req2_addr), .req_wdata(req2_wdata),
      .sw_rst_req(sw_rst2_req), .done(done2), .rsp_rdata(rsp2_rdata), .busy(busy2),
      .OTG_DATA(otg2_data), .OTG_ADDR(otg2_addr), .OTG_RD_N(otg2_rd_n),
      .OTG_WR_N(otg2_wr_n), .OTG_CS_N(otg2_cs_n), .OTG_RST_N(otg2_rst_n)
   );

   int vecs = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [15:0] data;
      int          gap;
      int          done_cyc;
   } item_t;

   item_t sb[$];
   item_t it;
   int    cs_cnt = 0, stb_cnt = 0, oth_cnt = 0, st_off = -1, cs_hi = 0, gap = 0;
   int    done_seen = 0;
   bit    addr_bad = 0, data_bad = 0, idle_bad = 0, mon_en = 0;
   bit    stb_now, oth_now;

   // Monitor: accumulates pin activity per transaction and scores it at done.
   always @(negedge Clk) begin
      if (mon_en) begin
         if (otg_cs_n) begin
            cs_hi++;
            if (otg_data !== 16'hFFFF) idle_bad = 1;
         end else begin
            if (cs_cnt == 0) gap = cs_hi;
            cs_hi = 0;
            if (sb.size() == 0) begin
               data_bad = 1;
            end else begin
               if (otg_addr !== sb[0].addr) addr_bad = 1;
               stb_now = sb[0].wr ? !otg_wr_n : !otg_rd_n;
               oth_now = sb[0].wr ? !otg_rd_n : !otg_wr_n;
               if (stb_now) begin
                  if (stb_cnt == 0) st_off = cs_cnt;
                  stb_cnt++;
               end
               if (oth_now) oth_cnt++;
               if (sb[0].wr) begin
                  if (otg_data !== sb[0].data) data_bad = 1;
               end else if (otg_rd_n && otg_data !== 16'hFFFF) begin
                  data_bad = 1;
               end
            end
            cs_cnt++;
         end
         if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
               check("unexpected done", 32'd1, 32'd0);
            end else begin
               it = sb.pop_front();
               check("done latency", 32'(cyc), 32'(it.done_cyc));
               check("cs_n low cycles", 32'(cs_cnt), 32'(T_CS));
               check("strobe low cycles", 32'(stb_cnt), 32'(T_STB));
               check("strobe offset", 32'(st_off), 32'(T_OFF));
               check("wrong strobe", 32'(oth_cnt), 32'd0);
               check("addr held", 32'(addr_bad), 32'd0);
               check("bus data", 32'(data_bad), 32'd0);
               if (!it.wr) check("rsp_rdata", 32'(rsp_rdata), 32'(it.data));
               if (it.gap > 0) check("cs_n high gap", 32'(gap), 32'(it.gap));
            end
            cs_cnt = 0; stb_cnt = 0; oth_cnt = 0; st_off = -1;
            addr_bad = 0; data_bad = 0;
         end
      end
   end

   task automatic do_req(input logic wr, input logic [1:0] a, input logic [15:0] d,
                         input int exp_gap, output int acc);
      item_t n;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wr ? d : 16'h0;
      acc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (req_ready) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         check("accept timeout", 32'd0, 32'd1);
      end else begin
         n.wr = wr; n.addr = a; n.data = d; n.gap = exp_gap; n.done_cyc = acc + T_DONE;
         sb.push_back(n);
      end
      @(posedge Clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge Clk);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      @(posedge Clk); #1;
   endtask

   int  a0, a1, a2, n, n2, got, rd_lo, d2_cnt, d0;
   bit  rdy_bad;

   initial begin
      Reset = 1'b1; Reset2 = 1'b1;
      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; sw_rst_req = 0;
      req2_valid = 0; req2_write = 0; req2_addr = 0; req2_wdata = 0; sw_rst2_req = 0;
      dev_rom[0] = 16'h5A5A; dev_rom[1] = 16'h1234; dev_rom[2] = 16'hC3C3; dev_rom[3] = 16'h0F0F;

      // Reset values while Reset is held.
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("rst otg_rst_n", 32'(otg_rst_n), 32'd0);
      check("rst cs/rd/wr", {29'd0, otg_cs_n, otg_rd_n, otg_wr_n}, 32'd7);
      check("rst otg_addr", 32'(otg_addr), 32'd0);
      check("rst ready/done/busy", {29'd0, req_ready, done, busy}, 32'd1);
      check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst bus", 32'(otg_data), 32'h0000FFFF);
      @(posedge Clk); #1;
      Reset = 1'b0; Reset2 = 1'b0; mon_en = 1;

      // Power-on chip reset pulse.
      n = 0; rdy_bad = 0;
      @(negedge Clk);
      while (!otg_rst_n && n < 100) begin
         if (req_ready) rdy_bad = 1;
         n++;
         @(negedge Clk);
      end
      check("por pulse length", 32'(n), 32'(T_RST));
      check("ready during por", 32'(rdy_bad), 32'd0);
      check("ready at por end", 32'(req_ready), 32'd1);
      @(posedge Clk); #1;

      // Single write, single read.
      do_req(1'b1, 2'b10, 16'hBEEF, 0, a0);
      wait_idle();
      do_req(1'b0, 2'b01, 16'h1234, 0, a0);
      wait_idle();

      // Back-to-back reads with req_valid held.
      d0 = done_seen;
      do_req(1'b0, 2'b00, 16'h5A5A, 0, a0);
      do_req(1'b0, 2'b10, 16'hC3C3, 1, a1);
      do_req(1'b0, 2'b11, 16'h0F0F, 1, a2);
      check("b2b period 1", 32'(a1 - a0), 32'(T_DONE));
      check("b2b period 2", 32'(a2 - a1), 32'(T_DONE));
      wait_idle();
      check("b2b done count", 32'(done_seen - d0), 32'd3);

      // Soft reset during the strobe of a write.
      do_req(1'b1, 2'b11, 16'hA55A, 0, a0);
      @(posedge Clk); #1;
      sw_rst_req = 1'b1;
      @(posedge Clk); #1;
      sw_rst_req = 1'b0;
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      check("done before soft reset", 32'(got), 32'd1);
      check("rst_n high at done", 32'(otg_rst_n), 32'd1);
      check("ready masked at done", 32'(req_ready), 32'd0);
      n = 0; rdy_bad = 0;
      @(negedge Clk);
      while (!otg_rst_n && n < 100) begin
         if (req_ready) rdy_bad = 1;
         n++;
         @(negedge Clk);
      end
      check("soft pulse length", 32'(n), 32'(T_RST));
      check("ready during soft pulse", 32'(rdy_bad), 32'd0);
      check("ready after soft pulse", 32'(req_ready), 32'd1);
      check("scoreboard after soft", 32'(sb.size()), 32'd0);

      // Soft reset in IDLE beats a same-cycle request.
      @(posedge Clk); #1;
      sw_rst_req = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'b00;
      @(negedge Clk);
      check("soft beats request", 32'(req_ready), 32'd0);
      @(posedge Clk); #1;
      sw_rst_req = 1'b0; req_valid = 1'b0;
      @(negedge Clk);
      check("soft from idle rst_n", {30'd0, otg_rst_n, busy}, 32'd1);
      for (int i = 0; i < 40 && !otg_rst_n; i++) @(negedge Clk);
      check("idle soft pulse ends", 32'(otg_rst_n), 32'd1);

      // Wide build: one full read, then Reset during the strobe of a second.
      @(posedge Clk); #1;
      req2_valid = 1'b1; req2_addr = 2'b01;
      n2 = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (req2_ready) begin
            n2 = cyc;
            break;
         end
      end
      check("dut2 accept", 32'(n2 >= 0), 32'd1);
      @(posedge Clk); #1;
      req2_valid = 1'b0;
      rd_lo = 0; got = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (!otg2_rd_n) rd_lo++;
         if (done2) begin
            got = cyc;
            break;
         end
      end
      check("dut2 done latency", 32'(got - n2), 32'(T2_DONE));
      check("dut2 strobe length", 32'(rd_lo), 32'(T2_STB));
      check("dut2 rsp_rdata", rsp2_rdata, 32'hCAFEF00D);

      @(posedge Clk); #1;
      req2_valid = 1'b1; req2_addr = 2'b10;
      d2_cnt = 0;
      for (int i = 0; i < 20 && !req2_ready; i++) @(negedge Clk);
      @(posedge Clk); #1;
      req2_valid = 1'b0;
      for (int i = 0; i < 20 && otg2_rd_n; i++) begin
         @(negedge Clk);
         if (done2) d2_cnt++;
      end
      check("dut2 strobe reached", 32'(otg2_rd_n), 32'd0);
      @(posedge Clk); #1;
      Reset2 = 1'b1;
      @(negedge Clk);
      if (done2) d2_cnt++;
      @(negedge Clk);
      check("abort strobes high", {29'd0, otg2_cs_n, otg2_rd_n, otg2_wr_n}, 32'd7);
      check("abort rst_n low", 32'(otg2_rst_n), 32'd0);
      check("abort rsp_rdata", rsp2_rdata, 32'd0);
      check("abort busy/ready", {30'd0, busy2, req2_ready}, 32'd2);
      @(posedge Clk); #1;
      Reset2 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         if (done2) d2_cnt++;
      end
      check("abort no done", 32'(d2_cnt), 32'd0);

      check("dut1 bus idle undriven", 32'(idle_bad), 32'd0);
      check("final scoreboard empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

endmodule
